// File: rtl/acc_cpu_core.sv
// -----------------------------------------------------------------------------
// acc_cpu_core
//   Parametrised multi-cycle accumulator CPU. Each instruction goes through
//   FETCH -> DECODE -> EXEC (-> MEM for LDA/STA). One valid/ready memory port
//   is shared by instruction fetch and data load/store. Every output is driven
//   straight from a flop.
//
//   The next fetch is requested on the same edge that leaves EXEC or MEM, as
//   long as enable is high on that edge. This keeps zero-wait ALU instructions
//   at 3 cycles. Straight after reset the request flop is clear, so the first
//   fetch takes one extra idle FETCH cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   enable     run enable; checked in FETCH before a request is raised
//   mem_req    memory request valid
//   mem_we     1 = write (STA), 0 = read
//   mem_addr   byte address
//   mem_wdata  store data
//   mem_ready  transfer completes on an edge where mem_req & mem_ready
//   mem_rdata  read data, valid in the completing cycle
//   pc         program counter
//   acc        accumulator
//   carry      carry (ADD) / borrow (SUB) flag
//   zero       zero flag
//   halted     high while in HALT
//   trap       sticky illegal-opcode flag
//
// Configuration macro
//   ACC_CPU_ILLEGAL_TRAP_EN : when defined, opcodes A-E set trap and jump to
//                             TRAP_VEC. When undefined they act as NOP and
//                             trap is tied low.
// -----------------------------------------------------------------------------
module acc_cpu_core #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VEC   = 'h100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] acc,
  output logic                  carry,
  output logic                  zero,
  output logic                  halted,
  output logic                  trap
);

  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_AND = 4'h4, OP_MOV = 4'h5, OP_LDA = 4'h6, OP_STA = 4'h7,
    OP_JMP = 4'h8, OP_JZ  = 4'h9, OP_HLT = 4'hF
  } op_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, operand_q, operand_d, mem_wdata_q, mem_wdata_d;
  logic                  carry_q, carry_d, zero_q, zero_d, halted_q, halted_d;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  op_t                   op_q, op_d;
  logic [4:0]            rs_q, rs_d;
  logic [15:0]           imm_q, imm_d;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  reg_we;
  logic                  rs_valid;
  logic [DATA_WIDTH-1:0] rs_val;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] diff, imm_data;
  logic [ADDR_WIDTH-1:0] imm_addr;
  logic                  next_fetch;

  // r0 and any index at or above NUM_REGS read as zero and ignore writes.
  assign rs_valid = (rs_q != 5'd0) && (int'(rs_q) < NUM_REGS);
  assign rs_val   = rs_valid ? regs_q[rs_q[RIDX_W-1:0]] : '0;
  assign imm_data = DATA_WIDTH'(imm_q);
  assign imm_addr = ADDR_WIDTH'(imm_q);
  assign sum      = {1'b0, acc_q} + {1'b0, operand_q};
  assign diff     = acc_q - operand_q;

`ifdef ACC_CPU_ILLEGAL_TRAP_EN
  logic trap_q, trap_d;
`endif

  // NOTE: every variable gets its default first, so no path through the
  // case statements leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    operand_d   = operand_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    halted_d    = halted_q;
    op_d        = op_q;
    rs_d        = rs_q;
    imm_d       = imm_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    reg_we      = 1'b0;
    next_fetch  = 1'b0;
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
    trap_d      = trap_q;
`endif

    case (state_q)
      S_FETCH: begin
        if (!mem_req_q) begin
          // Idle: raise a request only when enabled. Once raised, enable is ignored.
          if (enable) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_q;
          end
        end else if (mem_ready) begin
          op_d      = op_t'(mem_rdata[31:28]);
          rs_d      = mem_rdata[27:23];
          imm_d     = mem_rdata[15:0];
          pc_d      = pc_q + ADDR_WIDTH'(4);
          mem_req_d = 1'b0;
          state_d   = S_DECODE;
        end
      end

      S_DECODE: begin
        operand_d = rs_val;
        state_d   = S_EXEC;
      end

      S_EXEC: begin
        next_fetch = 1'b1;
        case (op_q)
          OP_NOP: ;
          OP_LDI: begin
            acc_d  = imm_data;
            zero_d = (imm_data == '0);
          end
          OP_ADD: begin
            acc_d   = sum[DATA_WIDTH-1:0];
            carry_d = sum[DATA_WIDTH];
            zero_d  = (sum[DATA_WIDTH-1:0] == '0);
          end
          OP_SUB: begin
            acc_d   = diff;
            carry_d = (acc_q < operand_q);
            zero_d  = (diff == '0);
          end
          OP_AND: begin
            acc_d  = acc_q & operand_q;
            zero_d = ((acc_q & operand_q) == '0);
          end
          OP_MOV: reg_we = rs_valid;
          OP_LDA, OP_STA: begin
            next_fetch  = 1'b0;
            state_d     = S_MEM;
            mem_req_d   = 1'b1;
            mem_we_d    = (op_q == OP_STA);
            mem_addr_d  = imm_addr;
            mem_wdata_d = acc_q;
          end
          OP_JMP: pc_d = imm_addr;
          // zero still holds the result of the previous instruction here.
          OP_JZ:  if (zero_q) pc_d = imm_addr;
          OP_HLT: begin
            next_fetch = 1'b0;
            state_d    = S_HALT;
            halted_d   = 1'b1;
          end
          default: begin
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
            trap_d = 1'b1;
            pc_d   = TRAP_VEC;
`endif
          end
        endcase
      end

      S_MEM: begin
        if (mem_ready) begin
          if (!mem_we_q) begin
            acc_d  = mem_rdata;
            zero_d = (mem_rdata == '0);
          end
          next_fetch = 1'b1;
        end
      end

      S_HALT: mem_req_d = 1'b0;

      default: state_d = S_FETCH;
    endcase

    // Issue the next fetch on the same edge that returns to FETCH.
    if (next_fetch) begin
      state_d    = S_FETCH;
      mem_req_d  = enable;
      mem_we_d   = 1'b0;
      mem_addr_d = pc_d;
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      acc_q       <= '0;
      operand_q   <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      halted_q    <= 1'b0;
      op_q        <= OP_NOP;
      rs_q        <= '0;
      imm_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      operand_q   <= operand_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      halted_q    <= halted_d;
      op_q        <= op_d;
      rs_q        <= rs_d;
      imm_q       <= imm_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // NOTE: the register file is reset because software may read registers
  // before it writes them and expects zero. This rules out a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[rs_q[RIDX_W-1:0]] <= acc_q;
    end
  end

`ifdef ACC_CPU_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trap_q <= 1'b0;
    else     trap_q <= trap_d;
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// -----------------------------------------------------------------------------
// tb_acc_cpu_core
//   Directed bench for acc_cpu_core. A small word memory serves fetches and
//   loads. Instructions come from imem, and stores land in dmem, which
//   shadows imem. mem_ready is raised after stall_cfg wait cycles of each
//   request. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_acc_cpu_core;

  localparam logic [31:0] HALT_W = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst, enable, mem_ready;
  logic        mem_req, mem_we, carry, zero, halted, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, acc;

  logic [31:0] imem   [0:127];
  logic [31:0] dmem   [0:127];
  logic        dvalid [0:127];
  int          stall_cfg;
  int          elapsed;
  logic [6:0]  widx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  acc_cpu_core dut (
    .clk(clk), .rst(rst), .enable(enable),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pc(pc), .acc(acc), .carry(carry), .zero(zero), .halted(halted), .trap(trap)
  );

  // Memory model.
  assign widx      = mem_addr[8:2];
  assign mem_ready = mem_req && (elapsed >= stall_cfg);
  assign mem_rdata = dvalid[widx] ? dmem[widx] : imem[widx];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) dvalid[i] <= 1'b0;
      elapsed <= 0;
    end else begin
      if (mem_req && !mem_ready) elapsed <= elapsed + 1;
      else                       elapsed <= 0;
      if (mem_req && mem_ready && mem_we) begin
        dmem[widx]   <= mem_wdata;
        dvalid[widx] <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rs,
                                      input logic [15:0] imm);
    return {op, rs, 7'd0, imm};
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < 128; i++) imem[i] = HALT_W;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds reset for two edges and releases it on a falling edge.
  task automatic reset_dut(input logic en);
    rst = 1'b1;
    enable = en;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    stall_cfg = 0;
    fill_halt();
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc); end
    checks++; if (acc !== 32'h0) begin errors++; $display("FAIL reset_acc: got %h want 0", acc); end
    checks++;
    if ({mem_req, mem_we, carry, zero, halted, trap} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000", {mem_req, mem_we, carry, zero, halted, trap});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      errors++; $display("FAIL reset_bus: got addr %h wdata %h want 0 0", mem_addr, mem_wdata);
    end
  endtask

  // LDI 5; ADD r0; HALT. halted must rise exactly on the 10th edge after reset release.
  task automatic test_ldi_add_halt();
    fill_halt();
    imem[0] = enc(4'h1, 5'd0, 16'd5);
    imem[1] = enc(4'h2, 5'd0, 16'd0);
    stall_cfg = 0;
    reset_dut(1'b1);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 9) begin
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b want 0 at cycle 9", halted); end
      end
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_cycle10: got %b want 1", halted); end
    checks++; if (acc !== 32'd5) begin errors++; $display("FAIL ldi_add_acc: got %h want 5", acc); end
    checks++;
    if ({carry, zero} !== 2'b00) begin errors++; $display("FAIL ldi_add_flags: got c=%b z=%b want 0 0", carry, zero); end
  endtask

  // acc=FFFFFFFF; MOV r1; LDI 1; ADD r1 (-> 0, c=1, z=1), optionally followed by SUB r1 (-> 1, c=1, z=0).
  task automatic test_carry_zero();
    int cyc;
    for (int pass = 0; pass < 2; pass++) begin
      fill_halt();
      imem[0]  = enc(4'h6, 5'd0, 16'h0060);
      imem[1]  = enc(4'h5, 5'd1, 16'd0);
      imem[2]  = enc(4'h1, 5'd0, 16'd1);
      imem[3]  = enc(4'h2, 5'd1, 16'd0);
      if (pass == 1) imem[4] = enc(4'h3, 5'd1, 16'd0);
      imem[24] = 32'hFFFF_FFFF;
      stall_cfg = 0;
      reset_dut(1'b1);
      run_to_halt(200, cyc);
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL carry_timeout: got halted=%b want 1", halted); end
      if (pass == 0) begin
        checks++; if (acc !== 32'h0) begin errors++; $display("FAIL add_wrap_acc: got %h want 0", acc); end
        checks++;
        if ({carry, zero} !== 2'b11) begin errors++; $display("FAIL add_wrap_flags: got c=%b z=%b want 1 1", carry, zero); end
      end else begin
        checks++; if (acc !== 32'h1) begin errors++; $display("FAIL sub_borrow_acc: got %h want 1", acc); end
        checks++;
        if ({carry, zero} !== 2'b10) begin errors++; $display("FAIL sub_borrow_flags: got c=%b z=%b want 1 0", carry, zero); end
      end
    end
  endtask

  // r3=F0F0; 0FF0 & r3 = 00F0 -> r4; 0F0F & r4 = 0 sets zero.
  task automatic test_and();
    int cyc;
    fill_halt();
    imem[0] = enc(4'h1, 5'd0, 16'hF0F0);
    imem[1] = enc(4'h5, 5'd3, 16'd0);
    imem[2] = enc(4'h1, 5'd0, 16'h0FF0);
    imem[3] = enc(4'h4, 5'd3, 16'd0);
    imem[4] = enc(4'h5, 5'd4, 16'd0);
    imem[5] = enc(4'h1, 5'd0, 16'h0F0F);
    imem[6] = enc(4'h4, 5'd4, 16'd0);
    stall_cfg = 0;
    reset_dut(1'b1);
    run_to_halt(200, cyc);
    checks++; if (acc !== 32'h0) begin errors++; $display("FAIL and_acc: got %h want 0", acc); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL and_zero: got %b want 1", zero); end
  endtask

  // LDI A5; STA 40; LDI 0; LDA 40; HALT with 3 wait cycles on every transfer.
  task automatic test_mem_wait();
    int          cyc, unstable, lda_waits;
    logic        req_prev, rdy_prev, we_prev;
    logic [31:0] addr_prev, wd_prev, sta_addr, sta_data;
    fill_halt();
    imem[0] = enc(4'h1, 5'd0, 16'h00A5);
    imem[1] = enc(4'h7, 5'd0, 16'h0040);
    imem[2] = enc(4'h1, 5'd0, 16'h0000);
    imem[3] = enc(4'h6, 5'd0, 16'h0040);
    stall_cfg = 3;
    reset_dut(1'b1);
    cyc = 0; unstable = 0; lda_waits = 0;
    req_prev = 1'b0; rdy_prev = 1'b0; we_prev = 1'b0;
    addr_prev = '0; wd_prev = '0; sta_addr = '0; sta_data = '0;
    while (!halted && cyc < 200) begin
      step();
      cyc++;
      if (mem_req && req_prev && !rdy_prev &&
          (mem_addr !== addr_prev || mem_we !== we_prev || mem_wdata !== wd_prev)) unstable++;
      if (mem_req && !mem_we && !mem_ready && mem_addr == 32'h40) lda_waits++;
      if (mem_req && mem_ready && mem_we) begin
        sta_addr = mem_addr;
        sta_data = mem_wdata;
      end
      req_prev = mem_req; rdy_prev = mem_ready; we_prev = mem_we;
      addr_prev = mem_addr; wd_prev = mem_wdata;
    end
    checks++; if (cyc !== 39) begin errors++; $display("FAIL mem_wait_cycles: got %0d want 39", cyc); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL bus_stable: got %0d changes want 0", unstable); end
    checks++; if (lda_waits !== 3) begin errors++; $display("FAIL lda_waits: got %0d want 3", lda_waits); end
    checks++;
    if ({sta_addr, sta_data} !== {32'h40, 32'hA5}) begin
      errors++; $display("FAIL sta_bus: got addr %h data %h want 40 a5", sta_addr, sta_data);
    end
    checks++; if (acc !== 32'hA5) begin errors++; $display("FAIL lda_acc: got %h want a5", acc); end
  endtask

  // JMP 10; LDI 0; JZ 80 (taken); at 80: LDI 1; JZ 80 (not taken); HALT at 88.
  task automatic test_branch();
    logic [31:0] fetch_q [$];
    logic [31:0] exp_q [$];
    int          cyc;
    fill_halt();
    imem[0]  = enc(4'h8, 5'd0, 16'h0010);
    imem[4]  = enc(4'h1, 5'd0, 16'h0000);
    imem[5]  = enc(4'h9, 5'd0, 16'h0080);
    imem[32] = enc(4'h1, 5'd0, 16'h0001);
    imem[33] = enc(4'h9, 5'd0, 16'h0080);
    exp_q = '{32'h0, 32'h10, 32'h14, 32'h80, 32'h84, 32'h88};
    stall_cfg = 0;
    reset_dut(1'b1);
    cyc = 0;
    while (!halted && cyc < 200) begin
      step();
      cyc++;
      if (mem_req && mem_ready && !mem_we) fetch_q.push_back(mem_addr);
    end
    checks++;
    if (fetch_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL branch_fetch_count: got %0d want %0d", fetch_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (fetch_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL branch_fetch%0d: got %h want %h", i, fetch_q[i], exp_q[i]);
        end
      end
    end
    checks++; if (pc !== 32'h8C) begin errors++; $display("FAIL branch_pc: got %h want 8c", pc); end
    checks++; if (acc !== 32'h1) begin errors++; $display("FAIL branch_acc: got %h want 1", acc); end
  endtask

  task automatic test_enable();
    int bad, n, cyc;
    fill_halt();
    imem[0] = enc(4'h1, 5'd0, 16'd7);
    stall_cfg = 2;
    reset_dut(1'b0);
    bad = 0;
    repeat (5) begin
      step();
      if (mem_req !== 1'b0 || pc !== 32'h0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL enable_idle: got %0d active cycles want 0", bad); end
    enable = 1'b1;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL enable_req: got req=%b addr=%h want 1 0", mem_req, mem_addr);
    end
    enable = 1'b0;
    n = 0;
    while (pc !== 32'h4 && n < 20) begin
      step();
      n++;
    end
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL enable_fetch_done: got pc %h want 4", pc); end
    bad = 0;
    repeat (6) begin
      step();
      if (mem_req !== 1'b0 || pc !== 32'h4) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL enable_freeze: got %0d active cycles want 0", bad); end
    enable = 1'b1;
    run_to_halt(60, cyc);
    checks++;
    if (halted !== 1'b1 || acc !== 32'd7) begin
      errors++; $display("FAIL enable_resume: got halted=%b acc=%h want 1 7", halted, acc);
    end
  endtask

  // LDI 3; op B; LDI 9; HALT. The trap vector 0x100 holds HALT.
  task automatic test_illegal();
    int cyc;
    fill_halt();
    imem[0] = enc(4'h1, 5'd0, 16'd3);
    imem[1] = 32'hB000_0000;
    imem[2] = enc(4'h1, 5'd0, 16'd9);
    stall_cfg = 0;
    reset_dut(1'b1);
    run_to_halt(200, cyc);
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
    checks++; if (trap !== 1'b1) begin errors++; $display("FAIL illegal_trap: got %b want 1", trap); end
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL illegal_pc: got %h want 104", pc); end
    checks++; if (acc !== 32'd3) begin errors++; $display("FAIL illegal_acc: got %h want 3", acc); end
`else
    checks++; if (trap !== 1'b0) begin errors++; $display("FAIL illegal_trap: got %b want 0", trap); end
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL illegal_pc: got %h want 10", pc); end
    checks++; if (acc !== 32'd9) begin errors++; $display("FAIL illegal_acc: got %h want 9", acc); end
`endif
  endtask

  task automatic test_reset_mid_mem();
    int n;
    fill_halt();
    imem[0]  = enc(4'h6, 5'd0, 16'h0040);
    imem[16] = 32'h0000_1234;
    stall_cfg = 5;
    reset_dut(1'b1);
    n = 0;
    while (!(mem_req && mem_addr == 32'h40) && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      errors++; $display("FAIL midmem_reach: got req=%b addr=%h want 1 40", mem_req, mem_addr);
    end
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || pc !== 32'h0 || acc !== 32'h0) begin
      errors++; $display("FAIL midmem_reset: got req=%b pc=%h acc=%h want 0 0 0", mem_req, pc, acc);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    stall_cfg = 0;
    test_reset();
    test_ldi_add_halt();
    test_carry_zero();
    test_and();
    test_mem_wait();
    test_branch();
    test_enable();
    test_illegal();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
